// File: rtl/cmplx_mul_rr_arbiter.sv
// Packet round-robin arbiter sharing one fixed-latency datapath between two requesters.
// Optional packet/stall counters are compiled in with CMPLX_ARB_STATS_EN.

module cmplx_mul_rr_lane #(
  parameter int FW    = 34,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lock,
  input  logic          in_vld,
  output logic          rdy,
  output logic          acc,
  input  logic          wr_en,
  input  logic [FW-1:0] wr_data,
  output logic          out_vld,
  output logic [FW-1:0] out_data,
  input  logic          out_rdy
`ifdef CMPLX_ARB_STATS_EN
  ,
  input  logic          in_last,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cred;
  logic [FW-1:0] mem [DEPTH];
  logic [AW:0]   wp, rp;
  logic          pop, full;

  assign rdy      = lock && (cred != '0);
  assign acc      = rdy && in_vld;
  assign out_vld  = (wp != rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop      = out_vld && out_rdy;
  assign out_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk)
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;

  // Credits mirror free FIFO slots including results still inside the datapath.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cred <= CW'(DEPTH);
      wp   <= '0;
      rp   <= '0;
    end else begin
      if (acc && !pop)      cred <= cred - 1'b1;
      else if (pop && !acc) cred <= cred + 1'b1;
      if (wr_en && !full) wp <= wp + 1'b1;
      if (pop)            rp <= rp + 1'b1;
    end
  end

`ifdef CMPLX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (acc && in_last) pkt_cnt <= pkt_cnt + 16'd1;
      if (lock && in_vld && (cred == '0) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

module cmplx_mul_rr_arbiter #(
  parameter int DATA_W      = 16,
  parameter int MODUL_WIDTH = 3,
  parameter int LAT         = 4,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in0_tvalid,
  output logic                   in0_tready,
  input  logic [2*DATA_W-1:0]    in0_tdata,
  input  logic                   in0_tfirst,
  input  logic                   in0_tlast,
  input  logic [MODUL_WIDTH-1:0] in0_modulation,
  input  logic                   in1_tvalid,
  output logic                   in1_tready,
  input  logic [2*DATA_W-1:0]    in1_tdata,
  input  logic                   in1_tfirst,
  input  logic                   in1_tlast,
  input  logic [MODUL_WIDTH-1:0] in1_modulation,
  output logic                   dp_tvalid,
  output logic [2*DATA_W-1:0]    dp_tdata,
  output logic                   dp_tfirst,
  output logic                   dp_tlast,
  output logic [MODUL_WIDTH-1:0] dp_modulation,
  input  logic                   dp_res_tvalid,
  input  logic [2*DATA_W-1:0]    dp_res_tdata,
  input  logic                   dp_res_tfirst,
  input  logic                   dp_res_tlast,
  output logic                   out0_tvalid,
  output logic [2*DATA_W-1:0]    out0_tdata,
  output logic                   out0_tfirst,
  output logic                   out0_tlast,
  input  logic                   out0_tready,
  output logic                   out1_tvalid,
  output logic [2*DATA_W-1:0]    out1_tdata,
  output logic                   out1_tfirst,
  output logic                   out1_tlast,
  input  logic                   out1_tready,
  output logic                   err_tag
`ifdef CMPLX_ARB_STATS_EN
  ,
  output logic [15:0]            pkt_cnt0,
  output logic [15:0]            pkt_cnt1,
  output logic [15:0]            stall_cnt0,
  output logic [15:0]            stall_cnt1
`endif
);
  localparam int DW = 2 * DATA_W;
  localparam int FW = DW + 2;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t                         state, state_nxt;
  logic                           last_grant, lg_nxt;
  logic [1:0]                     in_vld, in_first, in_last, req, lock, rdy, acc, out_vld, out_rdy;
  logic [1:0][DW-1:0]             in_data;
  logic [1:0][MODUL_WIDTH-1:0]    in_mod;
  logic [1:0][FW-1:0]             out_word;
  logic                           sel;
  // Stage 0 is the issue register itself; stage LAT lines up with dp_res_*.
  logic [LAT:0]                   vld_pipe, id_pipe;

  assign in_vld   = {in1_tvalid, in0_tvalid};
  assign in_first = {in1_tfirst, in0_tfirst};
  assign in_last  = {in1_tlast, in0_tlast};
  assign in_data  = {in1_tdata, in0_tdata};
  assign in_mod   = {in1_modulation, in0_modulation};
  assign out_rdy  = {out1_tready, out0_tready};
  assign req      = in_vld & in_first;
  assign lock     = {state == LOCK1, state == LOCK0};
  assign sel      = acc[1];

  assign {in1_tready, in0_tready} = rdy;
  assign {out1_tvalid, out0_tvalid} = out_vld;
  assign {out0_tdata, out0_tfirst, out0_tlast} = out_word[0];
  assign {out1_tdata, out1_tfirst, out1_tlast} = out_word[1];
  assign dp_tvalid = vld_pipe[0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= lg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lg_nxt    = last_grant;
    case (state)
      IDLE:
        if (req[0] && req[1]) state_nxt = last_grant ? LOCK0 : LOCK1;
        else if (req[0])      state_nxt = LOCK0;
        else if (req[1])      state_nxt = LOCK1;
      LOCK0:
        if (acc[0] && in_last[0]) begin
          state_nxt = IDLE;
          lg_nxt    = 1'b0;
        end
      LOCK1:
        if (acc[1] && in_last[1]) begin
          state_nxt = IDLE;
          lg_nxt    = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_pipe      <= '0;
      id_pipe       <= '0;
      dp_tdata      <= '0;
      dp_tfirst     <= 1'b0;
      dp_tlast      <= 1'b0;
      dp_modulation <= '0;
      err_tag       <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], |acc};
      id_pipe  <= {id_pipe[LAT-1:0], sel};
      if (|acc) begin
        dp_tdata      <= in_data[sel];
        dp_tfirst     <= in_first[sel];
        dp_tlast      <= in_last[sel];
        dp_modulation <= in_mod[sel];
      end
      if (dp_res_tvalid ^ vld_pipe[LAT]) err_tag <= 1'b1;
    end
  end

`ifdef CMPLX_ARB_STATS_EN
  logic [1:0][15:0] pkt_cnt, stall_cnt;
  assign {pkt_cnt1, pkt_cnt0}     = pkt_cnt;
  assign {stall_cnt1, stall_cnt0} = stall_cnt;
`endif

  for (genvar k = 0; k < 2; k++) begin : g_lane
    cmplx_mul_rr_lane #(.FW(FW), .DEPTH(DEPTH)) u_lane (
      .clk       (clk),
      .rstn      (rstn),
      .lock      (lock[k]),
      .in_vld    (in_vld[k]),
      .rdy       (rdy[k]),
      .acc       (acc[k]),
      .wr_en     (dp_res_tvalid && vld_pipe[LAT] && (id_pipe[LAT] == 1'(k))),
      .wr_data   ({dp_res_tdata, dp_res_tfirst, dp_res_tlast}),
      .out_vld   (out_vld[k]),
      .out_data  (out_word[k]),
      .out_rdy   (out_rdy[k])
`ifdef CMPLX_ARB_STATS_EN
      ,
      .in_last   (in_last[k]),
      .pkt_cnt   (pkt_cnt[k]),
      .stall_cnt (stall_cnt[k])
`endif
    );
  end
endmodule

// File: tb/tb_cmplx_mul_rr_arbiter.sv
// Bench for cmplx_mul_rr_arbiter: directed scenarios plus random traffic against a
// packet-level reference model with a behavioural LAT-cycle datapath.

module tb_cmplx_mul_rr_arbiter;
  localparam int DATA_W = 16, MW = 3, LAT = 4, DEPTH = 8, DW = 2 * DATA_W;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
    logic [MW-1:0] m;
  } beat_t;

  logic clk = 1'b0, rstn = 1'b0;
  logic in0_tvalid = 0, in0_tready, in0_tfirst = 0, in0_tlast = 0;
  logic in1_tvalid = 0, in1_tready, in1_tfirst = 0, in1_tlast = 0;
  logic [DW-1:0] in0_tdata = '0, in1_tdata = '0;
  logic [MW-1:0] in0_modulation = '0, in1_modulation = '0;
  logic dp_tvalid, dp_tfirst, dp_tlast;
  logic [DW-1:0] dp_tdata;
  logic [MW-1:0] dp_modulation;
  logic dp_res_tvalid = 0, dp_res_tfirst = 0, dp_res_tlast = 0;
  logic [DW-1:0] dp_res_tdata = '0;
  logic out0_tvalid, out0_tfirst, out0_tlast, out0_tready = 0;
  logic out1_tvalid, out1_tfirst, out1_tlast, out1_tready = 0;
  logic [DW-1:0] out0_tdata, out1_tdata;
  logic err_tag;
`ifdef CMPLX_ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1, stall_cnt0, stall_cnt1;
`endif

  always #5 clk = ~clk;

  cmplx_mul_rr_arbiter #(.DATA_W(DATA_W), .MODUL_WIDTH(MW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .in0_tvalid(in0_tvalid), .in0_tready(in0_tready), .in0_tdata(in0_tdata),
    .in0_tfirst(in0_tfirst), .in0_tlast(in0_tlast), .in0_modulation(in0_modulation),
    .in1_tvalid(in1_tvalid), .in1_tready(in1_tready), .in1_tdata(in1_tdata),
    .in1_tfirst(in1_tfirst), .in1_tlast(in1_tlast), .in1_modulation(in1_modulation),
    .dp_tvalid(dp_tvalid), .dp_tdata(dp_tdata), .dp_tfirst(dp_tfirst), .dp_tlast(dp_tlast),
    .dp_modulation(dp_modulation),
    .dp_res_tvalid(dp_res_tvalid), .dp_res_tdata(dp_res_tdata),
    .dp_res_tfirst(dp_res_tfirst), .dp_res_tlast(dp_res_tlast),
    .out0_tvalid(out0_tvalid), .out0_tdata(out0_tdata), .out0_tfirst(out0_tfirst),
    .out0_tlast(out0_tlast), .out0_tready(out0_tready),
    .out1_tvalid(out1_tvalid), .out1_tdata(out1_tdata), .out1_tfirst(out1_tfirst),
    .out1_tlast(out1_tlast), .out1_tready(out1_tready),
    .err_tag(err_tag)
`ifdef CMPLX_ARB_STATS_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
`endif
  );

  int n_chk = 0, n_err = 0;
  beat_t drv_q [2][$];
  beat_t exp_q [2][$];
  int vprob [2], rprob [2];
  int cred [2], acc_cnt [2], pop_cnt [2], ov_cnt [2];
  int pkt_m [2], stall_m [2];
  int owner = -1, last_g = 1;
  bit in_pkt [2];
  bit err_exp = 0, inject = 0, rst_seen = 0, prev_v = 0;
  beat_t prev_b;
  bit hv [LAT+1];
  beat_t hb [LAT+1];
  int grants [$];
  int cyc = 0, dpv_cnt = 0, first_acc = -1, first_out = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dpf(input logic [DW-1:0] x);
    return {x[DATA_W-1:0], ~x[DW-1:DATA_W]};
  endfunction

  function automatic bit busy();
    return (drv_q[0].size() + drv_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0;
  endfunction

  task automatic model_reset();
    owner = -1; last_g = 1; err_exp = 0; prev_v = 0;
    for (int k = 0; k < 2; k++) begin
      cred[k] = DEPTH; pkt_m[k] = 0; stall_m[k] = 0; in_pkt[k] = 0;
      exp_q[k].delete();
    end
    for (int i = 0; i <= LAT; i++) begin hv[i] = 0; hb[i] = '0; end
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step();
    beat_t b [2];
    bit v [2], a [2], p [2], ov [2], rq [2];
    logic [DW+1:0] ow [2];
    for (int k = 0; k < 2; k++) begin
      v[k] = (drv_q[k].size() != 0) && ($urandom_range(99) < vprob[k]);
      b[k] = v[k] ? drv_q[k][0] : '0;
    end
    {in0_tvalid, in0_tdata, in0_tfirst, in0_tlast, in0_modulation} = {v[0], b[0]};
    {in1_tvalid, in1_tdata, in1_tfirst, in1_tlast, in1_modulation} = {v[1], b[1]};
    out0_tready = ($urandom_range(99) < rprob[0]);
    out1_tready = ($urandom_range(99) < rprob[1]);
    for (int i = LAT; i > 0; i--) begin hv[i] = hv[i-1]; hb[i] = hb[i-1]; end
    hv[0] = dp_tvalid;
    hb[0] = {dp_tdata, dp_tfirst, dp_tlast, dp_modulation};
    dp_res_tvalid = hv[LAT] | inject;
    dp_res_tdata  = hv[LAT] ? dpf(hb[LAT].d) : 32'hDEAD_BEEF;
    dp_res_tfirst = hv[LAT] & hb[LAT].f;
    dp_res_tlast  = hv[LAT] & hb[LAT].l;
    #1;
    a[0] = in0_tvalid & in0_tready;  a[1] = in1_tvalid & in1_tready;
    ov[0] = out0_tvalid;             ov[1] = out1_tvalid;
    p[0] = out0_tvalid & out0_tready; p[1] = out1_tvalid & out1_tready;
    ow[0] = {out0_tdata, out0_tfirst, out0_tlast};
    ow[1] = {out1_tdata, out1_tfirst, out1_tlast};
    if (dp_tvalid) dpv_cnt++;
    if (ov[0] && first_out < 0) first_out = cyc;
    for (int k = 0; k < 2; k++) if (ov[k]) ov_cnt[k]++;
    if (rst_seen) begin
      chk("in0_tready", in0_tready, (owner == 0) && (cred[0] != 0));
      chk("in1_tready", in1_tready, (owner == 1) && (cred[1] != 0));
      chk("dp_tvalid", dp_tvalid, prev_v);
      if (prev_v) chk("dp_beat", {dp_tdata, dp_tfirst, dp_tlast, dp_modulation}, prev_b);
      chk("err_tag", err_tag, err_exp);
`ifdef CMPLX_ARB_STATS_EN
      chk("pkt_cnt0", pkt_cnt0, 16'(pkt_m[0]));
      chk("pkt_cnt1", pkt_cnt1, 16'(pkt_m[1]));
      chk("stall_cnt0", stall_cnt0, 16'(stall_m[0]));
      chk("stall_cnt1", stall_cnt1, 16'(stall_m[1]));
`endif
      for (int k = 0; k < 2; k++) if (p[k]) begin
        if (exp_q[k].size() == 0) chk($sformatf("out%0d_unexpected", k), 1, 0);
        else begin
          beat_t e = exp_q[k].pop_front();
          chk($sformatf("out%0d_beat", k), ow[k], {e.d, e.f, e.l});
        end
      end
    end
    if (!rstn) begin
      model_reset();
      rst_seen = 1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (owner == k && v[k] && cred[k] == 0 && stall_m[k] < 16'hFFFF) stall_m[k]++;
        if (a[k]) begin
          void'(drv_q[k].pop_front());
          exp_q[k].push_back({dpf(b[k].d), b[k].f, b[k].l, MW'(0)});
          acc_cnt[k]++;
          if (first_acc < 0 && k == 0) first_acc = cyc;
          if (b[k].f && !in_pkt[k]) begin grants.push_back(k); in_pkt[k] = 1; end
          if (b[k].l) begin in_pkt[k] = 0; pkt_m[k] = (pkt_m[k] + 1) & 16'hFFFF; end
        end
        if (p[k]) pop_cnt[k]++;
        cred[k] += int'(p[k]) - int'(a[k]);
        rq[k] = v[k] & b[k].f;
      end
      prev_v = a[0] | a[1];
      prev_b = a[1] ? b[1] : b[0];
      if (owner < 0) begin
        if (rq[0] && rq[1]) owner = (last_g == 1) ? 0 : 1;
        else if (rq[0])     owner = 0;
        else if (rq[1])     owner = 1;
      end else if (a[owner] && b[owner].l) begin
        last_g = owner;
        owner  = -1;
      end
      if (inject && !hv[LAT]) err_exp = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic add_pkt(input int k, input int len);
    logic [MW-1:0] m = MW'($urandom);
    for (int i = 0; i < len; i++)
      drv_q[k].push_back({DW'($urandom), i == 0, i == len - 1, m});
  endtask

  task automatic clr_obs();
    for (int k = 0; k < 2; k++) begin acc_cnt[k] = 0; pop_cnt[k] = 0; ov_cnt[k] = 0; end
    grants.delete(); dpv_cnt = 0; first_acc = -1; first_out = -1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) begin drv_q[k].delete(); vprob[k] = 100; rprob[k] = 100; end
    inject = 0;
    rstn = 0; step(); step(); rstn = 1;
    clr_obs();
  endtask

  task automatic run_until_idle(input int max, input string tag);
    int n = 0;
    while (busy() && n < max) begin step(); n++; end
    chk(tag, 64'(busy()), 0);
    repeat (3) step();
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_dp_tvalid", dp_tvalid, 0);
    chk("rst_out_valid", {out0_tvalid, out1_tvalid}, 0);
    chk("rst_tready", {in0_tready, in1_tready}, 0);

    // single packet latency
    add_pkt(0, 4);
    run_until_idle(200, "t1_drain");
    chk("t1_latency", 64'(first_out - first_acc), 64'(1 + LAT + 1));
    chk("t1_dp_beats", 64'(dpv_cnt), 4);
    chk("t1_out0_beats", 64'(pop_cnt[0]), 4);
    chk("t1_out1_silent", 64'(ov_cnt[1]), 0);

    // contention from reset: in0 first, then strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin add_pkt(0, 2); add_pkt(1, 2); end
    run_until_idle(300, "t2_drain");
    chk("t2_ngrants", 64'(grants.size()), 6);
    for (int i = 0; i < grants.size(); i++) chk($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(i % 2));

    // credit stall with blocked output
    do_reset();
    add_pkt(0, 20);
    rprob[0] = 0;
    repeat (30) step();
    chk("t3_accepted", 64'(acc_cnt[0]), 8);
    chk("t3_tready_low", in0_tready, 0);
    rprob[0] = 100;
    run_until_idle(300, "t3_drain");
    chk("t3_delivered", 64'(pop_cnt[0]), 20);

    // pop and accept together with three credits left
    do_reset();
    add_pkt(0, 20);
    rprob[0] = 0;
    repeat (20) step();
    vprob[0] = 0; rprob[0] = 100;
    repeat (3) step();
    vprob[0] = 100;
    step();
    rprob[0] = 0;
    repeat (15) step();
    chk("t4_accepted", 64'(acc_cnt[0]), 12);
    chk("t4_popped", 64'(pop_cnt[0]), 4);
    rprob[0] = 100;
    run_until_idle(300, "t4_drain");

    // orphan result
    do_reset();
    repeat (2) step();
    inject = 1; step(); inject = 0;
    chk("t5_err_tag", err_tag, 1);
    repeat (5) step();
    chk("t5_no_write", 64'(ov_cnt[0] + ov_cnt[1]), 0);

    // reset in the middle of a packet (err_tag still set from above)
    clr_obs();
    add_pkt(0, 2); add_pkt(0, 8);
    for (int n = 0; n < 50 && acc_cnt[0] < 4; n++) step();
    chk("t6_reach_beat3", 64'(acc_cnt[0]), 4);
    drv_q[0].delete();
    rstn = 0; step(); rstn = 1;
    chk("t6_dp_tvalid", dp_tvalid, 0);
    chk("t6_out_valid", {out0_tvalid, out1_tvalid}, 0);
    chk("t6_tready", {in0_tready, in1_tready}, 0);
    chk("t6_err_tag", err_tag, 0);
`ifdef CMPLX_ARB_STATS_EN
    chk("t6_pkt_cnt0", pkt_cnt0, 0);
    chk("t6_stall_cnt0", stall_cnt0, 0);
`endif
    clr_obs();
    add_pkt(0, 20);
    rprob[0] = 0;
    repeat (30) step();
    chk("t6_credits", 64'(acc_cnt[0]), 8);
    rprob[0] = 100;
    run_until_idle(300, "t6_drain");

    // random traffic
    do_reset();
    begin
      int tot [2] = '{0, 0};
      for (int i = 0; i < 15; i++)
        for (int k = 0; k < 2; k++) begin
          int len = $urandom_range(6, 1);
          add_pkt(k, len);
          tot[k] += len;
        end
      for (int k = 0; k < 2; k++) begin
        vprob[k] = $urandom_range(100, 40);
        rprob[k] = $urandom_range(100, 30);
      end
      run_until_idle(5000, "rand_drain");
      chk("rand_out0_beats", 64'(pop_cnt[0]), 64'(tot[0]));
      chk("rand_out1_beats", 64'(pop_cnt[1]), 64'(tot[1]));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
